// File: rtl/tmds_channel_encoder_pkg.sv
// Shared TMDS definitions: symbol/disparity widths, control tokens and the TERC4 code table.
package tmds_channel_encoder_pkg;

  localparam int unsigned SYM_W = 10;
  localparam int unsigned CNT_W = 5;

  localparam logic [SYM_W-1:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [SYM_W-1:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [SYM_W-1:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [SYM_W-1:0] CTRL_TOKEN_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    PERIOD_CTRL,
    PERIOD_VIDEO,
    PERIOD_ISLAND
  } period_t;

  function automatic logic [SYM_W-1:0] ctrl_token(input logic [1:0] c);
    logic [SYM_W-1:0] tok;
    tok = CTRL_TOKEN_00;
    unique case (c)
      2'b00: tok = CTRL_TOKEN_00;
      2'b01: tok = CTRL_TOKEN_01;
      2'b10: tok = CTRL_TOKEN_10;
      2'b11: tok = CTRL_TOKEN_11;
    endcase
    return tok;
  endfunction

  function automatic logic [SYM_W-1:0] terc4_code(input logic [3:0] nib);
    logic [SYM_W-1:0] code;
    code = 10'b1010011100;
    unique case (nib)
      4'h0: code = 10'b1010011100;
      4'h1: code = 10'b1001100011;
      4'h2: code = 10'b1011100100;
      4'h3: code = 10'b1011100010;
      4'h4: code = 10'b0101110001;
      4'h5: code = 10'b0100011110;
      4'h6: code = 10'b0110001110;
      4'h7: code = 10'b0100111100;
      4'h8: code = 10'b1011001100;
      4'h9: code = 10'b0100111001;
      4'hA: code = 10'b0110011100;
      4'hB: code = 10'b1011000110;
      4'hC: code = 10'b1010001110;
      4'hD: code = 10'b1001110001;
      4'hE: code = 10'b0101100011;
      4'hF: code = 10'b1011000011;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/tmds_terc4_lut.sv
// HDMI 1.4 TERC4 nibble-to-symbol lookup, purely combinational.
module tmds_terc4_lut
  import tmds_channel_encoder_pkg::*;
(
  input  logic [3:0]       aux,
  output logic [SYM_W-1:0] sym
);

  always_comb begin
    sym = terc4_code(aux);
  end

endmodule

// File: rtl/tmds_channel_encoder.sv
// One TMDS channel: 8b pixel / 2b control (/ TERC4 data island when TMDS_TERC4_EN is defined)
// to a 10b symbol, two register stages, running-disparity DC balance.
module tmds_channel_encoder
  import tmds_channel_encoder_pkg::*;
#(
  parameter int unsigned REVERSE_BITS = 0
)
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             vde,
  input  logic [1:0]       ctrl,
  input  logic [7:0]       data,
`ifdef TMDS_TERC4_EN
  input  logic             ade,
  input  logic [3:0]       aux,
`endif
  output logic [SYM_W-1:0] tmds_out
);

  logic [8:0]              q_m;
  logic                    vde_r;
  logic [1:0]              ctrl_r;
  logic signed [CNT_W-1:0] cnt;
  logic signed [CNT_W-1:0] cnt_nxt;
  logic signed [CNT_W-1:0] bal;
  logic [SYM_W-1:0]        sym;
  period_t                 period;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  // Ones minus zeros of a byte, in the disparity counter's signed width.
  function automatic logic signed [CNT_W-1:0] balance(input logic [7:0] v);
    logic signed [5:0] d6;
    d6 = $signed({1'b0, popcount8(v), 1'b0}) - 6'sd8;
    return d6[CNT_W-1:0];
  endfunction

  function automatic logic [8:0] qm_encode(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] q;
    n1       = popcount8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q        = '0;
    q[0]     = d[0];
    for (int unsigned i = 1; i < 8; i++)
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~use_xnor;
    return q;
  endfunction

  function automatic logic [SYM_W-1:0] orient(input logic [SYM_W-1:0] w);
    logic [SYM_W-1:0] r;
    r = w;
    if (REVERSE_BITS != 0)
      for (int unsigned i = 0; i < SYM_W; i++) r[i] = w[SYM_W-1-i];
    return r;
  endfunction

  // Stage 1: transition-minimised word plus the period qualifiers travelling with it.
`ifdef TMDS_TERC4_EN
  logic             ade_r;
  logic [3:0]       aux_r;
  logic [SYM_W-1:0] terc4_sym;

  tmds_terc4_lut u_terc4 (
    .aux (aux_r),
    .sym (terc4_sym)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ade_r <= 1'b0;
      aux_r <= '0;
    end else begin
      ade_r <= ade;
      aux_r <= aux;
    end
  end

  always_comb period = vde_r ? PERIOD_VIDEO : (ade_r ? PERIOD_ISLAND : PERIOD_CTRL);
`else
  always_comb period = vde_r ? PERIOD_VIDEO : PERIOD_CTRL;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      q_m    <= '0;
      vde_r  <= 1'b0;
      ctrl_r <= '0;
    end else begin
      q_m    <= qm_encode(data);
      vde_r  <= vde;
      ctrl_r <= ctrl;
    end
  end

  // Stage 2: pick the inverted/plain form that pulls the running disparity back toward zero.
  always_comb begin
    sym     = CTRL_TOKEN_00;
    cnt_nxt = '0;
    bal     = balance(q_m[7:0]);
    case (period)
      PERIOD_VIDEO: begin
        if ((cnt == '0) || (bal == '0)) begin
          if (q_m[8]) begin
            sym     = {2'b01, q_m[7:0]};
            cnt_nxt = cnt + bal;
          end else begin
            sym     = {2'b10, ~q_m[7:0]};
            cnt_nxt = cnt - bal;
          end
        end else if (cnt[CNT_W-1] == bal[CNT_W-1]) begin
          sym     = {1'b1, q_m[8], ~q_m[7:0]};
          cnt_nxt = cnt - bal + (q_m[8] ? 5'sd2 : 5'sd0);
        end else begin
          sym     = {1'b0, q_m[8], q_m[7:0]};
          cnt_nxt = cnt + bal - (q_m[8] ? 5'sd0 : 5'sd2);
        end
      end
`ifdef TMDS_TERC4_EN
      PERIOD_ISLAND: sym = terc4_sym;
`endif
      default: sym = ctrl_token(ctrl_r);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tmds_out <= orient(CTRL_TOKEN_00);
      cnt      <= '0;
    end else begin
      tmds_out <= orient(sym);
      cnt      <= cnt_nxt;
    end
  end

  cnt_range : assert property (@(posedge clk) disable iff (!rstn)
    (cnt >= -5'sd10) && (cnt <= 5'sd10));

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Bench for tmds_channel_encoder: directed literal vectors plus a per-cycle symbol/disparity model and decoder loopback.
module tb_tmds_channel_encoder;

  typedef struct {
    bit       rstn;
    bit       vde;
    bit [1:0] ctrl;
    bit [7:0] data;
    bit       ade;
    bit [3:0] aux;
  } vec_t;

  localparam bit [9:0] CTRL_TOK [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
  localparam bit [9:0] TERC4_TAB [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

  logic       tmds_clk = 1'b0;
  logic       rstn;
  logic       vde;
  logic [1:0] ctrl;
  logic [7:0] data;
  logic       ade;
  logic [3:0] aux;
  logic [9:0] tmds_out;

  int n_cmp = 0;
  int n_bad = 0;

  tmds_channel_encoder #(.REVERSE_BITS(0)) dut (
    .clk      (tmds_clk),
    .rstn     (rstn),
    .vde      (vde),
    .ctrl     (ctrl),
    .data     (data),
`ifdef TMDS_TERC4_EN
    .ade      (ade),
    .aux      (aux),
`endif
    .tmds_out (tmds_out)
  );

  always #5 tmds_clk = ~tmds_clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d (0x%0h) expected %0d (0x%0h)", name, $time, act, act, exp, exp);
    end
  endtask

  // Spec-level symbol choice: minimise transitions, then invert whenever that reduces |disparity|.
  function automatic bit [9:0] video_sym(input bit [7:0] d, input int cnt);
    bit [7:0] q;
    bit       xn;
    bit       inv;
    int       n1;
    xn   = ($countones(d) > 4) || (($countones(d) == 4) && !d[0]);
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    n1 = $countones(q);
    if ((cnt == 0) || (n1 == 4)) inv = xn;
    else inv = ((cnt > 0) && (n1 > 4)) || ((cnt < 0) && (n1 < 4));
    return {inv, ~xn, inv ? ~q : q};
  endfunction

  function automatic bit [10:0] tmds_decode(input bit [9:0] s);
    bit [7:0] w;
    bit [7:0] d;
    for (int t = 0; t < 4; t++)
      if (s == CTRL_TOK[t]) return {1'b0, 2'(t), 8'h00};
    w    = s[9] ? ~s[7:0] : s[7:0];
    d[0] = w[0];
    for (int i = 1; i < 8; i++) d[i] = s[8] ? (w[i] ^ w[i-1]) : ~(w[i] ^ w[i-1]);
    return {1'b1, 2'b00, d};
  endfunction

  // Model: inputs sampled at each edge wait one edge in 'pend', then become the expected output.
  initial begin : scoreboard
    vec_t      pend;
    vec_t      cur;
    vec_t      src;
    bit [9:0]  exp;
    bit [10:0] dec;
    bit        island;
    int        mcnt;
    pend = '{default: 0};
    mcnt = 0;
    forever begin
      @(posedge tmds_clk);
      cur    = '{rstn, vde, ctrl, data, ade, aux};
      src    = pend;
      island = 1'b0;
      if (!cur.rstn) begin
        src  = '{default: 0};
        pend = '{default: 0};
        mcnt = 0;
        exp  = CTRL_TOK[0];
      end else begin
        if (src.vde) begin
          exp  = video_sym(src.data, mcnt);
          mcnt = mcnt + 2 * $countones(exp) - 10;
        end
`ifdef TMDS_TERC4_EN
        else if (src.ade) begin
          exp    = TERC4_TAB[src.aux];
          mcnt   = 0;
          island = 1'b1;
        end
`endif
        else begin
          exp  = CTRL_TOK[src.ctrl];
          mcnt = 0;
        end
        pend = cur;
      end
      #1;
      check("sym", int'(tmds_out), int'(exp));
      check("cnt", $signed(dut.cnt), mcnt);
      if (!island) begin
        dec = tmds_decode(tmds_out);
        if (src.vde) check("loopback_video", int'({dec[10], dec[7:0]}), int'({1'b1, src.data}));
        else         check("loopback_ctrl", int'(dec[10:8]), int'({1'b0, src.ctrl}));
      end
    end
  end

  task automatic step(input vec_t v, input bit chk, input bit [9:0] exp, input string name);
    @(negedge tmds_clk);
    if (chk) check(name, int'(tmds_out), int'(exp));
    rstn = v.rstn;
    vde  = v.vde;
    ctrl = v.ctrl;
    data = v.data;
    ade  = v.ade;
    aux  = v.aux;
  endtask

  function automatic vec_t mk(input bit r, input bit v, input bit [1:0] c, input bit [7:0] d);
    return '{r, v, c, d, 1'b0, 4'h0};
  endfunction

  initial begin : stim
    vec_t     rows [20];
    bit [9:0] rexp [20];
    vec_t     v;
    // Each row's expectation is the symbol of the row two earlier.
    rows[0]  = mk(0, 1, 2'b00, 8'hAA); rexp[0]  = 10'h000;
    rows[1]  = mk(0, 1, 2'b00, 8'hAA); rexp[1]  = 10'h354;
    rows[2]  = mk(0, 1, 2'b00, 8'hAA); rexp[2]  = 10'h354;
    rows[3]  = mk(1, 1, 2'b00, 8'hAA); rexp[3]  = 10'h354;
    rows[4]  = mk(1, 1, 2'b00, 8'hAA); rexp[4]  = 10'h354;
    rows[5]  = mk(1, 0, 2'b00, 8'h00); rexp[5]  = 10'h233;
    rows[6]  = mk(1, 0, 2'b01, 8'h00); rexp[6]  = 10'h233;
    rows[7]  = mk(1, 0, 2'b10, 8'h00); rexp[7]  = 10'h354;
    rows[8]  = mk(1, 0, 2'b11, 8'h00); rexp[8]  = 10'h0AB;
    rows[9]  = mk(1, 1, 2'b00, 8'h00); rexp[9]  = 10'h154;
    rows[10] = mk(1, 1, 2'b00, 8'h00); rexp[10] = 10'h2AB;
    rows[11] = mk(1, 0, 2'b00, 8'h00); rexp[11] = 10'h100;
    rows[12] = mk(1, 0, 2'b00, 8'h00); rexp[12] = 10'h3FF;
    rows[13] = mk(1, 1, 2'b00, 8'h10); rexp[13] = 10'h354;
    rows[14] = mk(1, 1, 2'b00, 8'h10); rexp[14] = 10'h354;
    rows[15] = mk(0, 1, 2'b00, 8'h10); rexp[15] = 10'h1F0;
    rows[16] = mk(1, 1, 2'b00, 8'h10); rexp[16] = 10'h354;
    rows[17] = mk(1, 1, 2'b00, 8'h10); rexp[17] = 10'h354;
    rows[18] = mk(1, 1, 2'b00, 8'h10); rexp[18] = 10'h1F0;
    rows[19] = mk(1, 0, 2'b00, 8'h00); rexp[19] = 10'h1F0;

    rstn = rows[0].rstn;
    vde  = rows[0].vde;
    ctrl = rows[0].ctrl;
    data = rows[0].data;
    ade  = 1'b0;
    aux  = 4'h0;
    for (int k = 1; k < 20; k++) step(rows[k], 1'b1, rexp[k], $sformatf("dir_row%0d", k));

    for (int i = 0; i < 10000; i++) begin
      v.rstn = 1'b1;
      v.vde  = 1'($urandom_range(0, 1));
      v.ctrl = 2'($urandom_range(0, 3));
      v.data = 8'($urandom_range(0, 255));
`ifdef TMDS_TERC4_EN
      v.ade  = 1'($urandom_range(0, 1));
`else
      v.ade  = 1'b0;
`endif
      v.aux  = 4'($urandom_range(0, 15));
      step(v, 1'b0, 10'h000, "");
    end

`ifdef TMDS_TERC4_EN
    v = '{1'b1, 1'b0, 2'b00, 8'h00, 1'b1, 4'h0};
    step(v, 1'b0, 10'h000, "");
    v = '{1'b1, 1'b1, 2'b00, 8'h00, 1'b1, 4'h5};
    step(v, 1'b0, 10'h000, "");
    v = mk(1, 0, 2'b00, 8'h00);
    step(v, 1'b1, 10'b1010011100, "terc4_aux0");
    step(v, 1'b1, 10'h100, "terc4_video_wins");
`endif

    repeat (4) @(negedge tmds_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
